// File: rtl/xcel_reg_mgr_pkg.sv
// Shared types and constants for the accelerator register manager.
// Optional perf counter is enabled with XCEL_REG_MGR_PERF_EN.
package xcel_reg_mgr_pkg;

  localparam logic XCEL_TYPE_READ  = 1'b0;
  localparam logic XCEL_TYPE_WRITE = 1'b1;

  localparam int PERF_NBITS = 32;

  typedef enum logic {
    XCFG = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/xcel_resp_buf.sv
// Single-entry val/rdy pipeline register for xcel responses.
// Ports: enq_* from manager, deq_* to processor; reset active-low sync.
module xcel_resp_buf
  import xcel_reg_mgr_pkg::*;
#(
  parameter int p_nbits = 33
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
);

  logic               full;
  logic [p_nbits-1:0] data;

  // Accept when empty or when the held entry leaves this cycle.
  assign enq_rdy = !full || deq_rdy;
  assign deq_val = full;
  assign deq_msg = data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (enq_val && enq_rdy) begin
      full <= 1'b1;
      data <= enq_msg;
    end else if (deq_rdy) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/xcel_reg_mgr.sv
// Accelerator register manager: xcel req/resp val/rdy to xr0..xrN-1.
// Ports: clk, reset (active-low sync), xreq_*, xresp_*, go, done,
// result, args. Define XCEL_REG_MGR_PERF_EN for the BUSY cycle counter.
module xcel_reg_mgr
  import xcel_reg_mgr_pkg::*;
#(
  parameter int p_addr_nbits = 5,
  parameter int p_data_nbits = 32,
  parameter int p_nregs      = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   xreq_val,
  output logic                                   xreq_rdy,
  input  logic [p_addr_nbits+p_data_nbits:0]     xreq_msg,
  output logic                                   xresp_val,
  input  logic                                   xresp_rdy,
  output logic [p_data_nbits:0]                  xresp_msg,
  output logic                                   go,
  input  logic                                   done,
  input  logic [p_data_nbits-1:0]                result,
  output logic [(p_nregs-1)*p_data_nbits-1:0]    args
);

  localparam int AW       = p_addr_nbits;
  localparam int DW       = p_data_nbits;
  localparam int TYPE_BIT = AW + DW;
  localparam int ADDR_LSB = DW;
  localparam logic [AW-1:0] NREG_ADDR = AW'(p_nregs);

  logic          req_type;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;

  assign req_type = xreq_msg[TYPE_BIT];
  assign req_addr = xreq_msg[TYPE_BIT-1:ADDR_LSB];
  assign req_data = xreq_msg[DW-1:0];

  state_t        state;
  logic [DW-1:0] xr [p_nregs];

  logic          is_rd;
  logic          is_wr;
  logic          addr0;
  logic          busy;
  logic          in_range;
  logic          bypass;
  logic          reg_hit;
  logic          perf_hit;
  logic          acc_ok;
  logic          buf_rdy;
  logic          xfer;
  logic [DW-1:0] xr_rd;
  logic [DW-1:0] perf_rd;
  logic [DW-1:0] rd_data;
  logic [DW:0]   resp_msg;

  assign is_rd    = (req_type == XCEL_TYPE_READ);
  assign is_wr    = (req_type == XCEL_TYPE_WRITE);
  assign addr0    = (req_addr == '0);
  assign busy     = (state == BUSY);
  assign in_range = (req_addr < NREG_ADDR);
  assign bypass   = busy && addr0;
  assign reg_hit  = in_range && !bypass;

  // BUSY freezes args (no writes) and holds xr0 reads until done.
  assign acc_ok   = !busy || (is_rd && (!addr0 || done));
  assign xreq_rdy = reset && buf_rdy && acc_ok;
  assign xfer     = xreq_val && xreq_rdy;

  always_comb begin
    xr_rd = '0;
    for (int k = 0; k < p_nregs; k++) begin
      if (req_addr == AW'(k)) xr_rd = xr[k];
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      bypass:   rd_data = result;
      reg_hit:  rd_data = xr_rd;
      perf_hit: rd_data = perf_rd;
      default:  rd_data = '0;
    endcase
  end

  assign resp_msg = {req_type, is_wr ? '0 : rd_data};

  for (genvar k = 1; k < p_nregs; k++) begin : g_args
    assign args[(k-1)*DW +: DW] = xr[k];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= XCFG;
      go    <= 1'b0;
      for (int k = 0; k < p_nregs; k++) xr[k] <= '0;
    end else begin
      go <= 1'b0;
      unique case (state)
        XCFG: begin
          if (xfer && is_wr) begin
            for (int k = 0; k < p_nregs; k++) begin
              if (req_addr == AW'(k)) xr[k] <= req_data;
            end
            if (addr0) begin
              go    <= 1'b1;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (done) begin
            xr[0] <= result;
            state <= XCFG;
          end
        end
        default: state <= XCFG;
      endcase
    end
  end

`ifdef XCEL_REG_MGR_PERF_EN
  localparam logic [AW-1:0] PERF_ADDR = AW'(p_nregs);

  logic [PERF_NBITS-1:0] perf_cnt;
  logic [PERF_NBITS-1:0] perf_lat;
  logic [PERF_NBITS-1:0] perf_nxt;

  assign perf_nxt = (&perf_cnt) ? perf_cnt : perf_cnt + 1'b1;
  assign perf_hit = (req_addr == PERF_ADDR);
  assign perf_rd  = DW'(perf_lat);

  // Latched count includes the cycle in which done is seen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cnt <= '0;
      perf_lat <= '0;
    end else if (!busy) begin
      if (xfer && is_wr && addr0) perf_cnt <= '0;
    end else begin
      perf_cnt <= perf_nxt;
      if (done) perf_lat <= perf_nxt;
    end
  end
`else
  assign perf_hit = 1'b0;
  assign perf_rd  = '0;
`endif

  xcel_resp_buf #(
    .p_nbits (DW + 1)
  ) u_resp_buf (
    .clk     (clk),
    .reset   (reset),
    .enq_val (xfer),
    .enq_rdy (buf_rdy),
    .enq_msg (resp_msg),
    .deq_val (xresp_val),
    .deq_rdy (xresp_rdy),
    .deq_msg (xresp_msg)
  );

endmodule

// File: tb/tb_xcel_reg_mgr.sv
// Directed self-checking bench for xcel_reg_mgr (default parameters).
// Perf read-back expectation follows XCEL_REG_MGR_PERF_EN.
module tb_xcel_reg_mgr;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         xreq_val = 1'b0;
  logic         xreq_rdy;
  logic [37:0]  xreq_msg = '0;
  logic         xresp_val;
  logic         xresp_rdy = 1'b1;
  logic [32:0]  xresp_msg;
  logic         go;
  logic         done = 1'b0;
  logic [31:0]  result = '0;
  logic [223:0] args;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
  localparam logic [32:0] WR_ACK = {1'b1, 32'h0};

  xcel_reg_mgr dut (
    .clk       (clk),
    .reset     (reset),
    .xreq_val  (xreq_val),
    .xreq_rdy  (xreq_rdy),
    .xreq_msg  (xreq_msg),
    .xresp_val (xresp_val),
    .xresp_rdy (xresp_rdy),
    .xresp_msg (xresp_msg),
    .go        (go),
    .done      (done),
    .result    (result),
    .args      (args)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input string tag, input logic t,
                      input logic [4:0] a, input logic [31:0] d,
                      input logic [32:0] exp);
    int n;
    n = 0;
    xreq_val = 1'b1;
    xreq_msg = {t, a, d};
    #1;
    while (!xreq_rdy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_rdy"}, 64'(xreq_rdy), 64'd1);
    @(posedge clk);
    #1;
    xreq_val = 1'b0;
    chk({tag, "_val"}, 64'(xresp_val), 64'd1);
    chk({tag, "_msg"}, 64'(xresp_msg), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset, with a request presented
    xreq_val = 1'b1;
    xreq_msg = {WR, 5'd1, 32'h9};
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_rdy", 64'(xreq_rdy), 64'd0);
    chk("rst_val", 64'(xresp_val), 64'd0);
    chk("rst_go", 64'(go), 64'd0);
    chk("rst_args", args[63:0], 64'd0);
    xreq_val = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // argument write / read
    send("w_xr1", WR, 5'd1, 32'h5, WR_ACK);
    send("r_xr1", RD, 5'd1, 32'h0, {1'b0, 32'h5});
    chk("args_xr1", 64'(args[31:0]), 64'd5);
    send("w_xr2", WR, 5'd2, 32'h22, WR_ACK);

    // launch
    send("w_xr0", WR, 5'd0, 32'h1, WR_ACK);
    chk("go_hi", 64'(go), 64'd1);
    @(posedge clk);
    #1;
    chk("go_lo", 64'(go), 64'd0);

    // write while BUSY stalls
    xreq_val = 1'b1;
    xreq_msg = {WR, 5'd2, 32'h7};
    #1;
    chk("busy_wr_rdy0", 64'(xreq_rdy), 64'd0);
    @(posedge clk);
    #1;
    chk("busy_wr_rdy1", 64'(xreq_rdy), 64'd0);
    xreq_val = 1'b0;
    send("busy_r_xr2", RD, 5'd2, 32'h0, {1'b0, 32'h22});

    // xr0 read blocks until done, then bypasses result
    xreq_val = 1'b1;
    xreq_msg = {RD, 5'd0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("blk_rdy", 64'(xreq_rdy), 64'd0);
      @(posedge clk);
    end
    #1;
    done = 1'b1;
    result = 32'hDEAD_BEEF;
    #1;
    chk("done_rdy", 64'(xreq_rdy), 64'd1);
    @(posedge clk);
    #1;
    done = 1'b0;
    xreq_val = 1'b0;
    chk("byp_val", 64'(xresp_val), 64'd1);
    chk("byp_msg", 64'(xresp_msg), 64'({1'b0, 32'hDEAD_BEEF}));
    send("r_xr0_lat", RD, 5'd0, 32'h0, {1'b0, 32'hDEAD_BEEF});
    chk("args_xr2", 64'(args[63:32]), 64'h22);

    // done ignored in XCFG
    done = 1'b1;
    result = 32'h1234;
    @(posedge clk);
    #1;
    done = 1'b0;
    chk("xcfg_done_go", 64'(go), 64'd0);
    send("r_xr0_keep", RD, 5'd0, 32'h0, {1'b0, 32'hDEAD_BEEF});

    // response backpressure: 1, 0, 1
    xreq_val = 1'b1;
    xreq_msg = {RD, 5'd1, 32'h0};
    @(posedge clk);
    #1;
    chk("bp_msg0", 64'(xresp_msg), 64'({1'b0, 32'h5}));
    xreq_msg = {RD, 5'd2, 32'h0};
    xresp_rdy = 1'b0;
    #1;
    chk("bp_rdy", 64'(xreq_rdy), 64'd0);
    @(posedge clk);
    #1;
    chk("bp_hold_val", 64'(xresp_val), 64'd1);
    chk("bp_hold_msg", 64'(xresp_msg), 64'({1'b0, 32'h5}));
    xresp_rdy = 1'b1;
    @(posedge clk);
    #1;
    xreq_val = 1'b0;
    chk("bp_msg1", 64'(xresp_msg), 64'({1'b0, 32'h22}));
    @(posedge clk);
    #1;
    chk("bp_drain", 64'(xresp_val), 64'd0);

    // out-of-range addresses
    send("r_oor", RD, 5'd31, 32'h0, {1'b0, 32'h0});
    send("w_oor", WR, 5'd31, 32'hFF, WR_ACK);
    chk("oor_args_lo", args[63:0], 64'h0000_0022_0000_0005);
    chk("oor_args_hi", 64'(|args[223:64]), 64'd0);
    send("r_xr0_oor", RD, 5'd0, 32'h0, {1'b0, 32'hDEAD_BEEF});

    // 10-cycle run, then perf register at address 8
    send("w_run2", WR, 5'd0, 32'h1, WR_ACK);
    repeat (9) @(posedge clk);
    #1;
    done = 1'b1;
    result = 32'hABC;
    @(posedge clk);
    #1;
    done = 1'b0;
`ifdef XCEL_REG_MGR_PERF_EN
    send("r_perf", RD, 5'd8, 32'h0, {1'b0, 32'd10});
    send("w_perf", WR, 5'd8, 32'h55, WR_ACK);
    send("r_perf2", RD, 5'd8, 32'h0, {1'b0, 32'd10});
`else
    send("r_addr8", RD, 5'd8, 32'h0, {1'b0, 32'd0});
`endif
    send("r_run2", RD, 5'd0, 32'h0, {1'b0, 32'hABC});

    // reset in BUSY with a pending response
    send("w_run3", WR, 5'd0, 32'h2, WR_ACK);
    chk("run3_go", 64'(go), 64'd1);
    xresp_rdy = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_val", 64'(xresp_val), 64'd0);
    chk("mid_rst_go", 64'(go), 64'd0);
    reset = 1'b1;
    xresp_rdy = 1'b1;
    send("post_w_xr3", WR, 5'd3, 32'h9, WR_ACK);
    send("post_r_xr1", RD, 5'd1, 32'h0, {1'b0, 32'h0});
    send("post_r_xr0", RD, 5'd0, 32'h0, {1'b0, 32'h0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
